// File: rtl/alu6_pkg.sv
// Shared definitions for the alu6 issue/write-back stage: widths, ALU op
// codes, instruction field positions and the sequencer state type.
package alu6_pkg;

   localparam int W    = 6;
   localparam int NREG = 4;

   localparam logic [1:0] OP_ADD1  = 2'b00;
   localparam logic [1:0] OP_PASSA = 2'b01;
   localparam logic [1:0] OP_AND   = 2'b10;
   localparam logic [1:0] OP_SUB   = 2'b11;

   // Instruction layout: [7:6]=op, [5:4]=rd, [3:2]=rs1, [1:0]=rs2
   localparam int OP_HI  = 7;
   localparam int OP_LO  = 6;
   localparam int RD_HI  = 5;
   localparam int RD_LO  = 4;
   localparam int RS1_HI = 3;
   localparam int RS1_LO = 2;
   localparam int RS2_HI = 1;
   localparam int RS2_LO = 0;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      EXEC = 2'b01,
      RESP = 2'b10
   } state_t;

   function automatic logic [1:0] instr_op(input logic [7:0] i);
      return i[OP_HI:OP_LO];
   endfunction

   function automatic logic [1:0] instr_rd(input logic [7:0] i);
      return i[RD_HI:RD_LO];
   endfunction

   function automatic logic [1:0] instr_rs1(input logic [7:0] i);
      return i[RS1_HI:RS1_LO];
   endfunction

   function automatic logic [1:0] instr_rs2(input logic [7:0] i);
      return i[RS2_HI:RS2_LO];
   endfunction

endpackage

// File: rtl/alu6_regfile.sv
// 4 x W register file: two asynchronous read ports, a write-back port and a
// direct load port. When both writers target the same entry on the same edge
// the write-back value is kept and the load is dropped.
module alu6_regfile #(
   parameter int W    = 6,
   parameter int NREG = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [1:0]   ra1,
   input  logic [1:0]   ra2,
   output logic [W-1:0] rd1,
   output logic [W-1:0] rd2,
   input  logic         wb_en,
   input  logic [1:0]   wb_addr,
   input  logic [W-1:0] wb_data,
   input  logic         ld_en,
   input  logic [1:0]   ld_addr,
   input  logic [W-1:0] ld_data
);

   logic [W-1:0] rf_r [NREG];

   // Storage update: reset clears, write-back outranks the load strobe per entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            rf_r[i] <= {W{1'b0}};
         end
      end else begin
         for (int i = 0; i < NREG; i++) begin
            if (wb_en && (wb_addr == 2'(i))) begin
               rf_r[i] <= wb_data;
            end else if (ld_en && (ld_addr == 2'(i))) begin
               rf_r[i] <= ld_data;
            end else begin
               rf_r[i] <= rf_r[i];
            end
         end
      end
   end

   assign rd1 = rf_r[ra1];
   assign rd2 = rf_r[ra2];

endmodule

// File: rtl/alu6_exec_seq.sv
// Issue/write-back stage for the external 6-bit ALU. Accepts one instruction
// per IDLE->EXEC->RESP round trip, drives registered operands to the ALU,
// writes the returned result back and holds it on the result port.
// Optional feature macro: ALU6_EXEC_SEQ_FLAGS_EN adds res_zero / res_neg.
module alu6_exec_seq #(
   parameter int NREG = 4,
   parameter int W    = alu6_pkg::W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         instr_valid,
   output logic         instr_ready,
   input  logic [7:0]   instr,
   input  logic         ld_en,
   input  logic [1:0]   ld_addr,
   input  logic [W-1:0] ld_data,
   output logic [W-1:0] alu_a,
   output logic [W-1:0] alu_b,
   output logic [1:0]   alu_op,
   input  logic [W-1:0] alu_f,
   output logic         res_valid,
   input  logic         res_ready,
   output logic [W-1:0] res_data,
`ifdef ALU6_EXEC_SEQ_FLAGS_EN
   output logic         res_zero,
   output logic         res_neg,
`endif
   output logic [1:0]   res_rd
);

   import alu6_pkg::*;

   state_t       state_r;
   state_t       state_s;
   logic         instr_ready_s;
   logic         accept_s;
   logic         wb_en_s;
   logic [1:0]   rd_r;
   logic [W-1:0] alu_a_r;
   logic [W-1:0] alu_b_r;
   logic [1:0]   alu_op_r;
   logic         res_valid_r;
   logic [W-1:0] res_data_r;
   logic [1:0]   res_rd_r;
   logic [W-1:0] rs1_val_s;
   logic [W-1:0] rs2_val_s;

   alu6_regfile #(
      .W    (W),
      .NREG (NREG)
   ) u_regfile (
      .clk     (clk),
      .rst     (rst),
      .ra1     (instr_rs1(instr)),
      .ra2     (instr_rs2(instr)),
      .rd1     (rs1_val_s),
      .rd2     (rs2_val_s),
      .wb_en   (wb_en_s),
      .wb_addr (rd_r),
      .wb_data (alu_f),
      .ld_en   (ld_en),
      .ld_addr (ld_addr),
      .ld_data (ld_data)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state: one EXEC cycle after acceptance, then hold in RESP until consumed.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (instr_valid) begin
               state_s = EXEC;
            end else begin
               state_s = IDLE;
            end
         end
         EXEC: begin
            state_s = RESP;
         end
         RESP: begin
            if (res_ready) begin
               state_s = IDLE;
            end else begin
               state_s = RESP;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State-decoded controls; both are suppressed while reset is asserted.
   always_comb begin
      instr_ready_s = 1'b0;
      wb_en_s       = 1'b0;
      case (state_r)
         IDLE: begin
            instr_ready_s = ~rst;
         end
         EXEC: begin
            wb_en_s = ~rst;
         end
         RESP: begin
            instr_ready_s = 1'b0;
         end
         default: begin
            instr_ready_s = 1'b0;
         end
      endcase
      accept_s = instr_ready_s & instr_valid;
   end

   // Operand issue on handshake, result capture in EXEC, release on consume.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_r        <= 2'b00;
         alu_a_r     <= {W{1'b0}};
         alu_b_r     <= {W{1'b0}};
         alu_op_r    <= 2'b00;
         res_valid_r <= 1'b0;
         res_data_r  <= {W{1'b0}};
         res_rd_r    <= 2'b00;
      end else begin
         if (accept_s) begin
            rd_r     <= instr_rd(instr);
            alu_a_r  <= rs1_val_s;
            alu_b_r  <= rs2_val_s;
            alu_op_r <= instr_op(instr);
         end
         if (state_r == EXEC) begin
            res_data_r  <= alu_f;
            res_rd_r    <= rd_r;
            res_valid_r <= 1'b1;
         end else if ((state_r == RESP) && res_ready) begin
            res_valid_r <= 1'b0;
         end
      end
   end

`ifdef ALU6_EXEC_SEQ_FLAGS_EN
   logic res_zero_r;
   logic res_neg_r;

   // Result flags are captured alongside res_data and held through RESP.
   always_ff @(posedge clk) begin
      if (rst) begin
         res_zero_r <= 1'b0;
         res_neg_r  <= 1'b0;
      end else if (state_r == EXEC) begin
         res_zero_r <= (alu_f == {W{1'b0}});
         res_neg_r  <= alu_f[W-1];
      end else begin
         res_zero_r <= res_zero_r;
         res_neg_r  <= res_neg_r;
      end
   end

   assign res_zero = res_zero_r;
   assign res_neg  = res_neg_r;
`endif

   assign instr_ready = instr_ready_s;
   assign alu_a       = alu_a_r;
   assign alu_b       = alu_b_r;
   assign alu_op      = alu_op_r;
   assign res_valid   = res_valid_r;
   assign res_data    = res_data_r;
   assign res_rd      = res_rd_r;

endmodule

// File: tb/tb_alu6_exec_seq.sv
// Self-checking bench for alu6_exec_seq: the bench plays the role of the
// external ALU, keeps a transaction-level reference model, compares every
// cycle, and adds directed cases with hand-computed expectations.
module tb_alu6_exec_seq;
   import alu6_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       instr_valid;
   logic       instr_ready;
   logic [7:0] instr;
   logic       ld_en;
   logic [1:0] ld_addr;
   logic [5:0] ld_data;
   logic [5:0] alu_a, alu_b, alu_f;
   logic [1:0] alu_op;
   logic       res_valid;
   logic       res_ready;
   logic [5:0] res_data;
   logic [1:0] res_rd;
`ifdef ALU6_EXEC_SEQ_FLAGS_EN
   logic       res_zero, res_neg;
`endif

   always #5 clk = ~clk;

   alu6_exec_seq dut (
      .clk         (clk),
      .rst         (rst),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .instr       (instr),
      .ld_en       (ld_en),
      .ld_addr     (ld_addr),
      .ld_data     (ld_data),
      .alu_a       (alu_a),
      .alu_b       (alu_b),
      .alu_op      (alu_op),
      .alu_f       (alu_f),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .res_data    (res_data),
`ifdef ALU6_EXEC_SEQ_FLAGS_EN
      .res_zero    (res_zero),
      .res_neg     (res_neg),
`endif
      .res_rd      (res_rd)
   );

   function automatic logic [5:0] alu_ref(input logic [5:0] a, input logic [5:0] b,
                                          input logic [1:0] op);
      case (op)
         OP_ADD1:  return a + b + 6'd1;
         OP_PASSA: return a;
         OP_AND:   return a & b;
         default:  return a - b;
      endcase
   endfunction

   // The external combinational ALU.
   assign alu_f = alu_ref(alu_a, alu_b, alu_op);

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model (transaction level) ----------------
   logic [5:0] m_rf [4];
   logic [5:0] nrf  [4];
   bit         have_txn = 1'b0;
   bit         computed = 1'b0;
   logic [5:0] t_a, t_b;
   logic [1:0] t_op, t_rd;
   logic [5:0] f;
   logic [5:0] e_a = 6'd0, e_b = 6'd0, e_data = 6'd0;
   logic [1:0] e_op = 2'd0, e_rd = 2'd0;
   bit         e_valid = 1'b0, e_zero = 1'b0, e_neg = 1'b0;

   // Model step at each rising edge from the inputs the DUT also samples.
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) m_rf[i] = 6'd0;
         have_txn = 1'b0; computed = 1'b0;
         e_a = 6'd0; e_b = 6'd0; e_op = 2'd0;
         e_valid = 1'b0; e_data = 6'd0; e_rd = 2'd0; e_zero = 1'b0; e_neg = 1'b0;
      end else begin
         nrf = m_rf;
         if (ld_en) nrf[ld_addr] = ld_data;
         if (have_txn && !computed) begin
            f = alu_ref(t_a, t_b, t_op);
            nrf[t_rd] = f;
            e_valid = 1'b1; e_data = f; e_rd = t_rd;
            e_zero = (f == 6'd0); e_neg = f[5];
            computed = 1'b1;
         end else if (have_txn) begin
            if (res_ready) begin
               e_valid = 1'b0; have_txn = 1'b0;
            end
         end else if (instr_valid) begin
            t_op = instr[7:6]; t_rd = instr[5:4];
            t_a = m_rf[instr[3:2]]; t_b = m_rf[instr[1:0]];
            e_a = t_a; e_b = t_b; e_op = t_op;
            have_txn = 1'b1; computed = 1'b0;
         end
         m_rf = nrf;
      end
   end

   // Per-cycle comparison against the model on the falling edge.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("instr_ready", instr_ready, !have_txn && !rst);
         chk("res_valid", res_valid, e_valid);
         chk("res_data", res_data, e_data);
         chk("res_rd", res_rd, e_rd);
         chk("alu_a", alu_a, e_a);
         chk("alu_b", alu_b, e_b);
         chk("alu_op", alu_op, e_op);
`ifdef ALU6_EXEC_SEQ_FLAGS_EN
         chk("res_zero", res_zero, e_zero);
         chk("res_neg", res_neg, e_neg);
`endif
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [1:0] a, input logic [5:0] d);
      ld_en = 1'b1; ld_addr = a; ld_data = d;
      tick();
      ld_en = 1'b0;
   endtask

   // Offer an instruction and return once the handshake edge has passed.
   task automatic offer(input logic [1:0] op, input logic [1:0] rd,
                        input logic [1:0] rs1, input logic [1:0] rs2);
      bit got = 1'b0;
      instr = {op, rd, rs1, rs2};
      instr_valid = 1'b1;
      for (int k = 0; k < 20 && !got; k++) begin
         if (instr_ready) got = 1'b1;
         tick();
      end
      instr_valid = 1'b0;
      chk("accept", got, 1'b1);
   endtask

   // Full transaction: handshake, latency check, optional backpressure, consume.
   task automatic run(input logic [1:0] op, input logic [1:0] rd,
                      input logic [1:0] rs1, input logic [1:0] rs2,
                      input int hold, output logic [5:0] data);
      int edges;
      offer(op, rd, rs1, rs2);
      edges = 1;
      for (int k = 0; k < 10 && res_valid !== 1'b1; k++) begin
         tick();
         edges++;
      end
      chk("latency_edges", edges, 2);
      data = res_data;
      for (int k = 0; k < hold; k++) begin
         instr = {OP_PASSA, 2'd1, 2'd0, 2'd0};
         instr_valid = 1'b1;
         res_ready = 1'b0;
         tick();
         chk("bp_valid", res_valid, 1'b1);
         chk("bp_data", res_data, data);
         chk("bp_ready", instr_ready, 1'b0);
      end
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      instr_valid = 1'b0;
   endtask

   logic [5:0] d;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; instr_valid = 1'b0; instr = 8'd0; ld_en = 1'b0;
      ld_addr = 2'd0; ld_data = 6'd0; res_ready = 1'b0;
      tick();
      chk_en = 1'b1;
      chk("rst_instr_ready", instr_ready, 1'b0);
      chk("rst_res_valid", res_valid, 1'b0);
      chk("rst_alu_a", alu_a, 6'd0);
      chk("rst_res_data", res_data, 6'd0);
      rst = 1'b0;
      #1;
      chk("idle_instr_ready", instr_ready, 1'b1);

      // Main function with the four ops on r1=5, r2=3
      load(2'd1, 6'd5); load(2'd2, 6'd3);
      run(OP_ADD1, 2'd3, 2'd1, 2'd2, 0, d);
      chk("add1_data", d, 6'd9);
      chk("add1_model", e_data, 6'd9);
      chk("add1_rd", res_rd, 2'd3);
      chk("add1_alu_a", alu_a, 6'd5);
      chk("add1_alu_b", alu_b, 6'd3);
      run(OP_PASSA, 2'd0, 2'd3, 2'd0, 0, d);
      chk("rf3_after_add", d, 6'd9);
      run(OP_SUB, 2'd3, 2'd1, 2'd2, 0, d);
      chk("sub_data", d, 6'd2);
      run(OP_AND, 2'd3, 2'd1, 2'd2, 0, d);
      chk("and_data", d, 6'd1);
      run(OP_PASSA, 2'd3, 2'd1, 2'd2, 0, d);
      chk("passa_data", d, 6'd5);

      // Wrap-around boundaries
      load(2'd1, 6'd63); load(2'd2, 6'd0);
      run(OP_ADD1, 2'd0, 2'd1, 2'd2, 0, d);
      chk("wrap_add", d, 6'd0);
`ifdef ALU6_EXEC_SEQ_FLAGS_EN
      chk("wrap_add_zero", res_zero, 1'b1);
`endif
      load(2'd1, 6'd0); load(2'd2, 6'd1);
      run(OP_SUB, 2'd0, 2'd1, 2'd2, 0, d);
      chk("wrap_sub", d, 6'd63);
      chk("wrap_sub_model", e_data, 6'd63);
`ifdef ALU6_EXEC_SEQ_FLAGS_EN
      chk("wrap_sub_neg", res_neg, 1'b1);
`endif

      // Backpressure: 5 stalled cycles with a competing instruction offered
      load(2'd1, 6'd5); load(2'd2, 6'd3);
      run(OP_ADD1, 2'd3, 2'd1, 2'd2, 5, d);
      chk("bp_result", d, 6'd9);
      chk("bp_back_idle", instr_ready, 1'b1);
      run(OP_PASSA, 2'd0, 2'd1, 2'd0, 0, d);
      chk("bp_r1_untouched", d, 6'd5);

      // Collision: load and write-back to r3 on the EXEC edge
      load(2'd1, 6'd5); load(2'd2, 6'd3);
      offer(OP_ADD1, 2'd3, 2'd1, 2'd2);
      ld_en = 1'b1; ld_addr = 2'd3; ld_data = 6'd7;
      tick();
      ld_en = 1'b0;
      res_ready = 1'b1; tick(); res_ready = 1'b0;
      run(OP_PASSA, 2'd0, 2'd3, 2'd0, 0, d);
      chk("collide_same", d, 6'd9);

      // Different targets: both writes land
      offer(OP_ADD1, 2'd3, 2'd1, 2'd2);
      ld_en = 1'b1; ld_addr = 2'd0; ld_data = 6'd7;
      tick();
      ld_en = 1'b0;
      res_ready = 1'b1; tick(); res_ready = 1'b0;
      run(OP_PASSA, 2'd2, 2'd0, 2'd0, 0, d);
      chk("collide_diff_r0", d, 6'd7);
      run(OP_PASSA, 2'd2, 2'd3, 2'd0, 0, d);
      chk("collide_diff_r3", d, 6'd9);

      // Load and accept on the same edge read the old value
      load(2'd1, 6'd11);
      ld_en = 1'b1; ld_addr = 2'd1; ld_data = 6'd22;
      offer(OP_PASSA, 2'd2, 2'd1, 2'd0);
      ld_en = 1'b0;
      chk("same_edge_old", alu_a, 6'd11);
      res_ready = 1'b1; tick(); tick(); res_ready = 1'b0;

      // Reset during EXEC abandons the instruction
      offer(OP_ADD1, 2'd3, 2'd1, 2'd2);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      chk("rexec_valid", res_valid, 1'b0);
      chk("rexec_ready", instr_ready, 1'b1);
      run(OP_PASSA, 2'd0, 2'd1, 2'd0, 0, d);
      chk("rexec_rf_clear", d, 6'd0);

      // Randomized traffic against the model
      for (int n = 0; n < 1500; n++) begin
         rst         = ($urandom_range(0, 79) == 0);
         instr_valid = 1'($urandom_range(0, 1));
         instr       = 8'($urandom);
         ld_en       = ($urandom_range(0, 3) == 0);
         ld_addr     = 2'($urandom);
         ld_data     = ($urandom_range(0, 3) == 0) ? 6'd63 : 6'($urandom);
         res_ready   = ($urandom_range(0, 2) != 0);
         tick();
      end
      rst = 1'b0; instr_valid = 1'b0; ld_en = 1'b0; res_ready = 1'b1;
      tick(); tick(); tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
